mtimer: RTL

- Machine timer peripheral: the source end of the machine timer interrupt (MTIP) consumed by the CSR unit's timer-interrupt input.
- Holds a 64-bit free-running mtime counter with a programmable prescaler and a 64-bit mtimecmp register.
- Asserts o_tip while mtime >= mtimecmp.
- Sits on the core's memory-mapped peripheral bus as a single-beat req/ack responder; also exports mtime for a future time/timeh CSR.

---
 rtl/mtimer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mtimer.sv
// Machine timer peripheral: 64-bit mtime with prescaler, 64-bit mtimecmp,
// level interrupt o_tip while mtime >= mtimecmp, single-beat req/ack bus.
//
// Bus handshake: the initiator raises i_req (with i_we/i_addr/i_wdata) and
// holds it until o_ack. In IDLE a high i_req is sampled on the clock edge,
// where any write is also performed. The following cycle is ACK: o_ack is
// high for exactly that one cycle, with o_rdata/o_err valid. The block then
// returns to IDLE regardless of i_req. o_rdata and o_err are 0 whenever
// o_ack is 0.
module mtimer #(
    parameter int          PRESC_W = 16,
    parameter logic [31:0] HART_ID = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_tip,
    output logic [63:0] o_mtime
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // Bus FSM state; kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_nxt;

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;
    logic               tip_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic        addr_ok;
    logic        ro_hit;
    logic        bad;
    logic        take;
    logic        wr_en;
    logic        tick;
    logic [31:0] rd_mux;
    logic [31:0] presc_rd;

    // Address decode and the request strobes for this edge.
    always_comb begin
        addr_ok = (i_addr[1:0] == 2'b00) && (i_addr <= 5'h18);
        ro_hit  = (i_addr == 5'h14) || (i_addr == 5'h18);
        bad     = !addr_ok || (i_we && ro_hit);
        take    = (state == IDLE) && i_req;
        wr_en   = take && i_we && !bad;
        tick    = (presc_cnt == prescale);
    end

    // Read mux over the pre-edge register values.
    always_comb begin
        presc_rd               = '0;
        presc_rd[PRESC_W-1:0]  = prescale;
        rd_mux                 = '0;
        case (i_addr)
            5'h00:   rd_mux = mtime[31:0];
            5'h04:   rd_mux = mtime[63:32];
            5'h08:   rd_mux = mtimecmp[31:0];
            5'h0C:   rd_mux = mtimecmp[63:32];
            5'h10:   rd_mux = presc_rd;
            5'h14:   rd_mux = {31'b0, tip_q};
            5'h18:   rd_mux = HART_ID;
            default: rd_mux = '0;
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Bus FSM next state and the gated response outputs.
    always_comb begin
        state_nxt = state;
        o_ack     = 1'b0;
        o_rdata   = '0;
        o_err     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req) state_nxt = ACK;
            end
            ACK: begin
                state_nxt = IDLE;
                o_ack     = 1'b1;
                o_rdata   = rdata_q;
                o_err     = err_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the response at the sampling edge; writes and errors return 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (take) begin
            err_q   <= bad;
            rdata_q <= (bad || i_we) ? 32'h0 : rd_mux;
        end
    end

    // Prescaler, mtime, mtimecmp and the registered compare. A bus write to
    // an mtime half overrides the tick on the same edge (the tick is lost).
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            prescale  <= '0;
            presc_cnt <= '0;
            tip_q     <= 1'b0;
        end else begin
            if (wr_en && (i_addr == 5'h10)) begin
                prescale  <= i_wdata[PRESC_W-1:0];
                presc_cnt <= '0;
            end else if (tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end

            if (wr_en && (i_addr == 5'h00))      mtime[31:0]  <= i_wdata;
            else if (wr_en && (i_addr == 5'h04)) mtime[63:32] <= i_wdata;
            else if (tick)                       mtime        <= mtime + 64'd1;

            if (wr_en && (i_addr == 5'h08)) mtimecmp[31:0]  <= i_wdata;
            if (wr_en && (i_addr == 5'h0C)) mtimecmp[63:32] <= i_wdata;

            tip_q <= (mtime >= mtimecmp);
        end
    end

    assign o_tip   = tip_q;
    assign o_mtime = mtime;

endmodule
